piccolo_diffusion_matrix: RTL and testbench



---
 rtl/piccolo_pkg.sv | 17 +
 rtl/gf16_mix_col.sv | 14 +
 rtl/piccolo_diffusion_matrix.sv | 32 +++
 tb/tb_piccolo_diffusion_matrix.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/piccolo_pkg.sv
// piccolo_pkg: GF(2^4) helpers, word types and the Piccolo S-box shared by the diffusion datapath
package piccolo_pkg;
  localparam logic [3:0] GF_POLY = 4'h3;
  typedef logic [3:0] nibble_t;
  typedef logic [15:0] word_t;
  localparam nibble_t SBOX [16] = '{4'he, 4'h4, 4'hb, 4'h2, 4'h3, 4'h8, 4'h0, 4'h9,
                                    4'h1, 4'ha, 4'h7, 4'hf, 4'h6, 4'hc, 4'h5, 4'hd};
  function automatic nibble_t xtime(input nibble_t a);
    return {a[2:0], 1'b0} ^ (a[3] ? GF_POLY : 4'h0);
  endfunction
  function automatic nibble_t mul3(input nibble_t a);
    return xtime(a) ^ a;
  endfunction
  function automatic word_t sub_word(input word_t w);
    return {SBOX[w[15:12]], SBOX[w[11:8]], SBOX[w[7:4]], SBOX[w[3:0]]};
  endfunction
endpackage

// File: rtl/gf16_mix_col.sv
// gf16_mix_col: combinational product of a 4-nibble vector with the Piccolo circulant matrix M
module gf16_mix_col
  import piccolo_pkg::*;
(
  input  logic [15:0] x,
  output logic [15:0] y
);
  nibble_t x0, x1, x2, x3;
  assign {x0, x1, x2, x3} = x;
  assign y = {xtime(x0) ^ mul3(x1) ^ x2 ^ x3,
              x0 ^ xtime(x1) ^ mul3(x2) ^ x3,
              x0 ^ x1 ^ xtime(x2) ^ mul3(x3),
              mul3(x0) ^ x1 ^ x2 ^ xtime(x3)};
endmodule

// File: rtl/piccolo_diffusion_matrix.sv
// piccolo_diffusion_matrix: registered Piccolo M layer; with PICCOLO_FFUNC_EN defined computes full F = S(M(S(X)))
module piccolo_diffusion_matrix
  import piccolo_pkg::*;
#(
  parameter int REG_OUT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        out_valid,
  output logic [15:0] out_data
);
  word_t m_in, m_out, f_out;
`ifdef PICCOLO_FFUNC_EN
  assign m_in  = sub_word(in_data);
  assign f_out = sub_word(m_out);
`else
  assign m_in  = in_data;
  assign f_out = m_out;
`endif
  gf16_mix_col u_mix (.x(m_in), .y(m_out));
  always_ff @(posedge clk)
    out_valid <= reset ? 1'b0 : in_valid;
  if (REG_OUT != 0) begin : g_reg
    always_ff @(posedge clk)
      if (reset) out_data <= '0;
      else if (in_valid) out_data <= f_out;
  end else begin : g_comb
    assign out_data = f_out;
  end
endmodule

// File: tb/tb_piccolo_diffusion_matrix.sv
// tb_piccolo_diffusion_matrix: randomized bench against a generic GF(2^4) matrix-product model
module tb_piccolo_diffusion_matrix;
  logic clk = 0, reset = 1, in_valid = 0;
  logic [15:0] in_data = '0;
  logic out_valid;
  logic [15:0] out_data;
  int errors = 0, checks = 0;

  piccolo_diffusion_matrix #(.REG_OUT(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data));

  always #5 clk = ~clk;

  int coef [4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
  int sbox [16] = '{14, 4, 11, 2, 3, 8, 0, 9, 1, 10, 7, 15, 6, 12, 5, 13};

  function automatic int gmul(int a, int b);
    int p = 0;
    for (int i = 0; i < 4; i++) if ((b >> i) & 1) p ^= a << i;
    for (int k = 6; k >= 4; k--) if ((p >> k) & 1) p ^= 'h13 << (k - 4);
    return p;
  endfunction

  function automatic logic [15:0] apply_s(logic [15:0] w);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'(sbox[w[4*i +: 4]]);
    return r;
  endfunction

  function automatic logic [15:0] apply_m(logic [15:0] w);
    int x [4];
    logic [15:0] r = '0;
    for (int c = 0; c < 4; c++) x[c] = int'(w[15-4*c -: 4]);
    for (int rr = 0; rr < 4; rr++) begin
      int acc = 0;
      for (int c = 0; c < 4; c++) acc ^= gmul(coef[rr][c], x[c]);
      r[15-4*rr -: 4] = 4'(acc);
    end
    return r;
  endfunction

  function automatic logic [15:0] model(logic [15:0] w);
`ifdef PICCOLO_FFUNC_EN
    return apply_s(apply_m(apply_s(w)));
`else
    return apply_m(w);
`endif
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_check(input logic [15:0] d, input logic [15:0] exp, input string name);
    in_valid = 1; in_data = d;
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp) begin
      errors++;
      $display("FAIL %s: in=%h got valid=%b data=%h, want valid=1 data=%h", name, d, out_valid, out_data, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 1; in_data = 16'hffff;
    cycle(); cycle();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset: got valid=%b data=%h, want valid=0 data=0000", out_valid, out_data);
    end
    reset = 0; in_valid = 0;
  endtask

  task automatic test_zero();
`ifdef PICCOLO_FFUNC_EN
    send_check(16'h0000, 16'h5555, "zero_ffunc");
`else
    send_check(16'h0000, 16'h0000, "zero");
`endif
  endtask

  task automatic test_unit_vectors();
    logic [15:0] ins [4] = '{16'h1000, 16'h0100, 16'h0010, 16'h0001};
    logic [15:0] outs [4] = '{16'h2113, 16'h3211, 16'h1321, 16'h1132};
    for (int i = 0; i < 4; i++)
`ifdef PICCOLO_FFUNC_EN
      send_check(ins[i], model(ins[i]), "unit_vector");
`else
      send_check(ins[i], outs[i], "unit_vector");
`endif
  endtask

  task automatic test_known();
`ifdef PICCOLO_FFUNC_EN
    send_check(16'ha1c7, model(16'ha1c7), "known_a1c7");
`else
    send_check(16'ha1c7, 16'hf89e, "known_a1c7");
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [15:0] d = 16'($urandom);
      send_check(d, model(d), "random");
    end
  endtask

  task automatic test_linearity();
`ifndef PICCOLO_FFUNC_EN
    for (int i = 0; i < 10; i++) begin
      logic [15:0] a = 16'($urandom), b = 16'($urandom);
      send_check(a ^ b, model(a) ^ model(b), "linearity");
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [15:0] w [3];
    for (int i = 0; i < 3; i++) w[i] = 16'($urandom);
    for (int i = 0; i < 3; i++) send_check(w[i], model(w[i]), "stream");
    in_valid = 0; in_data = 16'($urandom);
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b0 || out_data !== model(w[2])) begin
        errors++;
        $display("FAIL stream_hold: got valid=%b data=%h, want valid=0 data=%h", out_valid, out_data, model(w[2]));
      end
    end
  endtask

  task automatic test_reset_midstream();
    send_check(16'h1234, model(16'h1234), "pre_reset");
    reset = 1; in_valid = 1; in_data = 16'h5678;
    cycle();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_midstream: got valid=%b data=%h, want valid=0 data=0000", out_valid, out_data);
    end
    reset = 0;
    send_check(16'h9abc, model(16'h9abc), "post_reset");
    in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_unit_vectors();
    test_known();
    test_random();
    test_linearity();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
